// File: rtl/dmem_responder_pkg.sv
// Shared LSU/data-memory types and defaults used by the data-memory responder.
package dmem_responder_pkg;

  localparam int XLEN                     = 32;
  localparam int DATA_MEM_SIZE            = 4096;
  localparam int DMEM_WAIT_STATES_DEFAULT = 1;

  typedef enum logic [3:0] {
    LSU_NONE     = 4'd0,
    LSU_LOAD_B   = 4'd1,
    LSU_LOAD_H   = 4'd2,
    LSU_LOAD_W   = 4'd3,
    LSU_LOAD_BU  = 4'd4,
    LSU_LOAD_HU  = 4'd5,
    LSU_STORE_B  = 4'd6,
    LSU_STORE_H  = 4'd7,
    LSU_STORE_W  = 4'd8
  } lsu_ls_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_ls_align.sv
// Combinational byte-lane steering for one LSU access against a 32-bit little-endian RAM word.
module dmem_ls_align
  import dmem_responder_pkg::*;
(
  input  lsu_ls_t         i_op,
  input  logic [1:0]      i_addrLo,
  input  logic [XLEN-1:0] i_ramWord,
  input  logic [XLEN-1:0] i_wdata,
  output logic [3:0]      o_byteEn,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_lane;

  // Bring the addressed byte down to lane 0 so every load extends from bit 0.
  assign w_lane  = i_ramWord >> {i_addrLo, 3'b000};
  assign o_wdata = i_wdata << {i_addrLo, 3'b000};

  always_comb begin
    o_byteEn   = 4'b0000;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_op)
      LSU_LOAD_B:  o_rdata = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      LSU_LOAD_BU: o_rdata = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      LSU_LOAD_H: begin
        o_rdata    = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
        o_misalign = i_addrLo[0];
      end
      LSU_LOAD_HU: begin
        o_rdata    = {{(XLEN-16){1'b0}}, w_lane[15:0]};
        o_misalign = i_addrLo[0];
      end
      LSU_LOAD_W: begin
        o_rdata    = i_ramWord;
        o_misalign = |i_addrLo;
      end
      LSU_STORE_B: o_byteEn = 4'b0001 << i_addrLo;
      LSU_STORE_H: begin
        o_byteEn   = 4'b0011 << i_addrLo;
        o_misalign = i_addrLo[0];
      end
      LSU_STORE_W: begin
        o_byteEn   = 4'b1111;
        o_misalign = |i_addrLo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one LSU request, waits WAIT_STATES cycles, commits, responds.
// Optional DMEM_ERR_CHECK_EN enables misalignment/range errors; otherwise addresses align and wrap.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int XLEN          = dmem_responder_pkg::XLEN,
  parameter int DATA_MEM_SIZE = dmem_responder_pkg::DATA_MEM_SIZE,
  parameter int WAIT_STATES   = DMEM_WAIT_STATES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  lsu_ls_t         req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW    = $clog2(DATA_MEM_SIZE);
  localparam int WORDS = DATA_MEM_SIZE / 4;

  dmem_state_t     r_state;
  dmem_state_t     w_nextState;
  logic [3:0]      r_cnt;
  lsu_ls_t         r_op;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rspRdata;
  logic            r_rspErr;
  logic [XLEN-1:0] r_mem [WORDS];

  logic            w_accept;
  logic            w_commit;
  lsu_ls_t         w_accOp;
  logic [XLEN-1:0] w_accAddr;
  logic [XLEN-1:0] w_accWdata;
  logic [1:0]      w_addrLo;
  logic [AW-3:0]   w_wordIdx;
  logic [XLEN-1:0] w_ramWord;
  logic [3:0]      w_byteEn;
  logic [XLEN-1:0] w_shWdata;
  logic [XLEN-1:0] w_loadData;
  logic            w_misalign;
  logic            w_err;

  assign w_accept = req_valid && req_ready;

  // With zero wait states the commit edge is the accept edge, so the live request is used.
  assign w_accOp    = (r_state == DMEM_IDLE) ? req_op    : r_op;
  assign w_accAddr  = (r_state == DMEM_IDLE) ? req_addr  : r_addr;
  assign w_accWdata = (r_state == DMEM_IDLE) ? req_wdata : r_wdata;
  assign w_wordIdx  = w_accAddr[AW-1:2];
  assign w_ramWord  = r_mem[w_wordIdx];

`ifdef DMEM_ERR_CHECK_EN
  logic w_outOfRange;
  assign w_addrLo     = w_accAddr[1:0];
  assign w_outOfRange = |w_accAddr[XLEN-1:AW];
  assign w_err        = (w_accOp != LSU_NONE) && (w_misalign || w_outOfRange);
`else
  logic w_unusedBits;
  always_comb begin
    w_addrLo = w_accAddr[1:0];
    case (w_accOp)
      LSU_LOAD_H, LSU_LOAD_HU, LSU_STORE_H: w_addrLo = {w_accAddr[1], 1'b0};
      LSU_LOAD_W, LSU_STORE_W:              w_addrLo = 2'b00;
      default: ;
    endcase
  end
  assign w_err        = 1'b0;
  assign w_unusedBits = ^{w_misalign, w_accAddr[XLEN-1:AW]};
`endif

  dmem_ls_align u_align (
    .i_op       (w_accOp),
    .i_addrLo   (w_addrLo),
    .i_ramWord  (w_ramWord),
    .i_wdata    (w_accWdata),
    .o_byteEn   (w_byteEn),
    .o_wdata    (w_shWdata),
    .o_rdata    (w_loadData),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= DMEM_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      DMEM_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            w_nextState = DMEM_RESP;
            w_commit    = 1'b1;
          end else begin
            w_nextState = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_nextState = DMEM_RESP;
          w_commit    = 1'b1;
        end
      end
      DMEM_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = DMEM_IDLE;
      end
      default: w_nextState = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_op       <= LSU_NONE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_state == DMEM_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rspRdata <= w_err ? '0 : w_loadData;
        r_rspErr   <= w_err;
      end
    end
  end

  // RAM is deliberately not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_commit && !rst && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) r_mem[w_wordIdx][8*b +: 8] <= w_shWdata[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves load/store requests from the core's LSU.
- The LSU issues operations encoded as lsu_ls_t; this block executes them against a byte-addressed, little-endian RAM after a configurable number of wait states.
- Returns load data, sign- or zero-extended to XLEN, over a valid/ready response channel.
- Sits between the LSU and the data RAM and is the backing store for DATA_MEM_SIZE.

Parameters:
- XLEN, 32, data/address width.
- DATA_MEM_SIZE, 4096, RAM size in bytes; power of two.
- WAIT_STATES, 1, idle cycles between request acceptance and the memory access; 0..15.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_op  input  lsu_ls_t (4)  operation: LSU_NONE, LSU_LOAD_*, LSU_STORE_*.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-aligned (B uses [7:0], H uses [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  LSU accepts response.
- rsp_rdata  output  XLEN  extended load data; 0 for stores, LSU_NONE and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- FSM states, from dmem_state_t:
  - DMEM_IDLE: req_ready=1, rsp_valid=0.
  - DMEM_WAIT: req_ready=0, rsp_valid=0.
  - DMEM_RESP: req_ready=0, rsp_valid=1.
- Request acceptance:
  - A request is accepted on a cycle with req_valid && req_ready.
  - On acceptance, op, addr and wdata are captured into registers; later changes on req_* are ignored.
  - Wait counter loads WAIT_STATES.
- Transitions:
  - IDLE to WAIT on accept if WAIT_STATES>0; IDLE to RESP on accept if WAIT_STATES==0.
  - WAIT: counter decrements each cycle; moves to RESP on the cycle the counter is 1.
  - Access latency: request accept to rsp_valid high is WAIT_STATES+1 cycles.
- Access commit:
  - The RAM read/write happens on the clock edge that enters RESP.
  - rsp_rdata and rsp_err are registered on that same edge and held stable while in RESP.
- Response handshake:
  - RESP to IDLE on rsp_valid && rsp_ready.
  - Back-pressure holds all response outputs stable.
  - No new request is accepted in the cycle the response completes (req_ready only rises in IDLE).
- Loads:
  - B/BU read byte addr; H/HU read bytes addr, addr+1; W reads 4 bytes, little-endian.
  - B and H are sign-extended; BU and HU are zero-extended.
- Stores:
  - Write only the addressed bytes; other bytes are untouched.
  - rsp_rdata=0.
- LSU_NONE: accepted as a no-op; response has rsp_rdata=0, rsp_err=0; no RAM access.
- Errors (see the optional feature):
  - Misaligned: H/HU/STORE_H with addr[0]=1; W/STORE_W with addr[1:0]!=0.
  - Out of range: addr >= DATA_MEM_SIZE.
  - On error: rsp_err=1, rsp_rdata=0, no RAM write.
- Reset:
  - FSM to IDLE; req_ready=1 (combinational from the state); rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - A transaction in flight is dropped; a store not yet committed is never written.
  - RAM contents are not reset.
- Reset wins over any simultaneous handshake.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: the misalignment and range checks above are active.
- Undefined:
  - rsp_err is tied to 0.
  - Address low bits are forced aligned: H clears bit 0, W clears bits [1:0].
  - Address wraps modulo DATA_MEM_SIZE.
  - Every access completes.

Decomposition:
- Add to the shared package:
  - dmem_state_t {DMEM_IDLE, DMEM_WAIT, DMEM_RESP}.
  - DMEM_WAIT_STATES_DEFAULT=1.
- Reuse the existing lsu_ls_t, XLEN and DATA_MEM_SIZE.
- One combinational sub-module, dmem_ls_align:
  - Given op, addr[1:0], the RAM word and wdata, it produces byte enables, shifted write data, the extended load result and the misalign flag.
- The top level holds the FSM, counter, capture registers and RAM.

Test Plan:
- WAIT_STATES=1: STORE_W addr 0x10 data 0xDEADBEEF, then LOAD_W 0x10 -> rsp_valid 2 cycles after accept, rsp_rdata 0xDEADBEEF, rsp_err 0.
- After the above: LOAD_B 0x13 -> 0xFFFFFFDE; LOAD_BU 0x13 -> 0x000000DE; LOAD_H 0x12 -> 0xFFFFDEAD; LOAD_HU 0x10 -> 0x0000BEEF.
- STORE_B 0x11 data 0x00000055 over 0xDEADBEEF -> subsequent LOAD_W 0x10 returns 0xDEAD55EF.
- With DMEM_ERR_CHECK_EN: LOAD_W 0x12 -> rsp_err 1, rsp_rdata 0. STORE_H 0x21 -> rsp_err 1, memory at 0x20 unchanged. LOAD_W 0x1000 -> rsp_err 1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready 0 throughout; accepts the next request only after the handshake and the return to IDLE.
- Assert rst in DMEM_WAIT during a STORE_W 0x30 data 0x12345678 -> next cycle req_ready 1, rsp_valid 0; LOAD_W 0x30 returns the old value, not 0x12345678.
